// File: rtl/record_streamer_pkg.sv
// Shared types and default sizing for the ROM record streamer.
package record_streamer_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_IP_WIDTH   = 32;
    localparam int DEF_URL_WIDTH  = 512;
    localparam int DEF_FIFO_DEPTH = 2;

    // Sequencer states: IDLE waits for start, RUN issues ROM reads,
    // DRAIN lets in-flight reads and buffered records leave.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One streamed record at the default widths; the top level builds the
    // same layout from its own width parameters.
    typedef struct packed {
        logic [DEF_IP_WIDTH-1:0]   ip;
        logic [DEF_URL_WIDTH-1:0]  url;
        logic [DEF_ADDR_WIDTH-1:0] index;
        logic                      last;
    } record_t;

endpackage

// File: rtl/record_fifo.sv
// Small synchronous FIFO of records with occupancy and first-word-valid head.
module record_fifo
    import record_streamer_pkg::*;
#(
    parameter int  DEPTH = DEF_FIFO_DEPTH,
    parameter type T     = record_t,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  T                 i_data,
    input  logic             i_pop,
    output T                 o_data,
    output logic             o_valid,
    output logic [OCC_W-1:0] o_occ
);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full    = (r_occ == OCC_W'(DEPTH));
    assign w_do_pop  = i_pop && (r_occ != '0);
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Capture pushed records into storage.
    // NOTE: the storage array has no reset; occupancy alone decides what is
    // valid, and the head is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Advance pointers and track occupancy.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_occ <= r_occ - OCC_W'(1);
            end
        end
    end

    assign o_valid = (r_occ != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_occ   = r_occ;

endmodule

// File: rtl/record_streamer.sv
// Walks a registered IP/URL ROM pair and streams each record over valid/ready,
// with start/stop, loop mode, credit-based backpressure and pass counting.
module record_streamer
    import record_streamer_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int IP_WIDTH   = DEF_IP_WIDTH,
    parameter int URL_WIDTH  = DEF_URL_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop,
    input  logic [ADDR_WIDTH:0]   num_records,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  rom_read,
    input  logic [IP_WIDTH-1:0]   rom_ip_data,
    input  logic [URL_WIDTH-1:0]  rom_url_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IP_WIDTH-1:0]   out_ip,
    output logic [URL_WIDTH-1:0]  out_url,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           pass_count
);

    typedef struct packed {
        logic [IP_WIDTH-1:0]   ip;
        logic [URL_WIDTH-1:0]  url;
        logic [ADDR_WIDTH-1:0] index;
        logic                  last;
    } rec_t;

    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int CRED_W = OCC_W + 1;
    localparam logic [ADDR_WIDTH:0] MAX_RECORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] COUNT_ONE   = (ADDR_WIDTH + 1)'(1);

    state_t                r_state;
    state_t                w_next_state;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_loop;
    logic                  r_rd_pending;
    logic [ADDR_WIDTH-1:0] r_rd_index;
    logic                  r_rd_last;
    logic                  r_done;
    logic [15:0]           r_pass_count;

    logic [ADDR_WIDTH:0]   w_clamped;
    logic                  w_issue;
    logic                  w_issue_last;
    logic                  w_pop;
    logic                  w_drain_empty;
    logic [OCC_W-1:0]      w_occ;
    logic [CRED_W-1:0]     w_used;
    logic [CRED_W-1:0]     w_limit;
    logic                  w_head_valid;
    rec_t                  w_head;
    rec_t                  w_push_rec;

    assign w_clamped = (num_records > MAX_RECORDS) ? MAX_RECORDS : num_records;
    assign w_pop     = w_head_valid && out_ready;

    // A read may issue while buffered + in-flight records, less the one
    // leaving this cycle, stay below the buffer size: no record can be lost.
    assign w_used  = CRED_W'(w_occ) + CRED_W'(r_rd_pending);
    assign w_limit = CRED_W'(FIFO_DEPTH) + CRED_W'(w_pop);

    assign w_issue_last = ({1'b0, r_addr} == (r_count - COUNT_ONE));

    // DRAIN may finish in the same cycle as the final transfer so that done
    // lands on the cycle right after it.
    assign w_drain_empty = !r_rd_pending &&
                           ((w_occ == '0) || ((w_occ == OCC_W'(1)) && w_pop));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and read-issue decision; stop wins over a same-cycle issue.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && (w_clamped != '0)) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    w_next_state = DRAIN;
                end else if (w_used < w_limit) begin
                    w_issue = 1'b1;
                    if (w_issue_last && !r_loop) begin
                        w_next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_drain_empty) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Pass setup, address counter and the one-deep in-flight read tracker.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr       <= '0;
            r_count      <= '0;
            r_loop       <= 1'b0;
            r_rd_pending <= 1'b0;
            r_rd_index   <= '0;
            r_rd_last    <= 1'b0;
        end else begin
            r_rd_pending <= w_issue;
            if ((r_state == IDLE) && start) begin
                r_count <= w_clamped;
                r_loop  <= loop;
                r_addr  <= '0;
            end else if (w_issue) begin
                r_rd_index <= r_addr;
                r_rd_last  <= w_issue_last;
                r_addr     <= w_issue_last ? '0 : r_addr + ADDR_WIDTH'(1);
            end
        end
    end

    // Done pulse and completed-pass counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done       <= 1'b0;
            r_pass_count <= '0;
        end else begin
            r_done <= ((r_state == IDLE) && start && (w_clamped == '0)) ||
                      ((r_state == DRAIN) && w_drain_empty);
            if ((r_state == IDLE) && start) begin
                r_pass_count <= '0;
            end else if (w_pop && w_head.last) begin
                r_pass_count <= r_pass_count + 16'd1;
            end
        end
    end

    // ROM data arrives the cycle after the read and is tagged with its origin.
    assign w_push_rec.ip    = rom_ip_data;
    assign w_push_rec.url   = rom_url_data;
    assign w_push_rec.index = r_rd_index;
    assign w_push_rec.last  = r_rd_last;

    record_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (rec_t)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (r_rd_pending),
        .i_data  (w_push_rec),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (w_head_valid),
        .o_occ   (w_occ)
    );

    assign rom_address = r_addr;
    assign rom_read    = w_issue;
    assign out_valid   = w_head_valid;
    assign out_ip      = w_head.ip;
    assign out_url     = w_head.url;
    assign out_index   = w_head.index;
    assign out_last    = w_head.last;
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign pass_count  = r_pass_count;

endmodule

// File: doc/record_streamer.md
# record_streamer

Sequencer that walks a pair of registered test-data ROMs (IP-address ROM and URL ROM sharing one address) and emits each record as a valid/ready stream. It is the parametrised successor of the bench-side ROM inserter: widths, depth and record count are configurable, and it adds start/stop control, loop mode, backpressure handling and pass counting. It sits between the ROM pair and the DUT's packet-build input in the anonymizer testbench and in on-chip self-test.

## Interface
- ADDR_WIDTH, 12, ROM address width; max records 2^ADDR_WIDTH
- IP_WIDTH, 32, IP-address record width
- URL_WIDTH, 512, URL record width
- FIFO_DEPTH, 2, output buffer entries; minimum 2, which sustains 1 record/cycle
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a pass; honoured only in IDLE
- stop  in  1  stop issuing reads; honoured in RUN
- loop  in  1  sampled at start; 1 = wrap to address 0 after last record and continue until stop
- num_records  in  ADDR_WIDTH+1  records per pass, sampled at start; values >2^ADDR_WIDTH clamp to 2^ADDR_WIDTH
- rom_address  out  ADDR_WIDTH  ROM read address
- rom_read  out  1  ROM read strobe
- rom_ip_data  in  IP_WIDTH  ROM data, valid the cycle after rom_read
- rom_url_data  in  URL_WIDTH  ROM data, valid the cycle after rom_read
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts
- out_ip  out  IP_WIDTH  record IP address
- out_url  out  URL_WIDTH  record URL
- out_index  out  ADDR_WIDTH  ROM address the record came from
- out_last  out  1  record is index num_records-1 of a pass
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on return to IDLE
- pass_count  out  16  completed passes since last start

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE, start=1: latch num_records (clamped) and loop, clear address and pass_count; go RUN. If num_records=0, stay IDLE and pulse done next cycle; no reads.
- RUN: issue rom_read at the current address when occ + inflight - pop < FIFO_DEPTH (occ = FIFO entries, inflight = reads not yet written, pop = out_valid & out_ready this cycle). Address increments per issued read.
- After issuing address num_records-1: loop=1 wraps to 0; loop=0 goes DRAIN.
- stop=1 in RUN: no read issued that cycle or after; go DRAIN. stop has priority over a same-cycle issue.
- DRAIN: no reads; leaves for IDLE with done pulse when inflight=0 and FIFO empty.
- ROM data is written to the FIFO with its address and last flag, one cycle after rom_read.
- Stream: out_* stable while out_valid & !out_ready; the record transfers on out_valid & out_ready.
- pass_count increments (wrapping at 2^16) on each transfer with out_last=1.
- start in RUN/DRAIN is ignored; stop in IDLE/DRAIN is ignored.

## Timing
- Reset: state IDLE, FIFO empty, all outputs 0 (rom_address, rom_read, out_valid, out_ip, out_url, out_index, out_last, busy, done, pass_count).
- Reset asserted mid-pass: all state is discarded immediately; out_valid drops asynchronously; no done pulse.
- start high in cycle 0: busy and rom_read at address 0 in cycle 1; data into FIFO at end of cycle 2; out_valid in cycle 3.
- out_ready held high: one record per cycle, gap-free, with FIFO_DEPTH=2.
- out_ready low: at most FIFO_DEPTH reads outstanding in total; no record lost or duplicated.
- done: one cycle, the cycle after the final transfer, coincident with busy falling.

## Structure
- Package record_streamer_pkg: state enum (IDLE, RUN, DRAIN), default width constants, and a record struct {ip, url, index, last}.
- One sub-module: record_fifo. It is a synchronous FIFO of record structs, parametrised by depth, with occupancy output and first-word valid.
- Credit/issue logic and address counter stay in the top level.

## Test plan
- num_records=4, loop=0, out_ready=1 -> indices 0,1,2,3 on consecutive cycles from cycle 3, out_last on 3, done the cycle after, pass_count=1.
- num_records=3, out_ready toggled 1,0,0,1,... -> 3 records in order, each held stable while stalled, rom_read never has more than 2 outstanding.
- loop=1, num_records=2, stop after 5 transfers -> index sequence 0,1,0,1,0(,1...), buffered records drained, done pulses, pass_count equals transfers with out_last.
- num_records=0 -> no rom_read, done pulse in cycle 1, busy stays 0.
- reset_n low during a stalled transfer at index 2 -> out_valid 0 immediately; after release, start gives index 0 again with pass_count=0.
- num_records=2^ADDR_WIDTH+1 -> clamped; last index 4095, out_last there, no address wrap.
